// File: rtl/fma16_issue.sv
// fma16_issue: command front-end for the combinational fma16 datapath.
// Accepts opcode commands over valid/ready and decodes them into fma16
// control bits. Commands are queued in a DEPTH-entry FIFO whose head drives
// the fma16 inputs. The fma16 result is captured into a tagged output
// register that honours res_ready backpressure.
module fma16_issue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic [15:0]                cmd_x,
    input  logic [15:0]                cmd_y,
    input  logic [15:0]                cmd_z,
    input  logic [1:0]                 cmd_rm,
    input  logic [3:0]                 cmd_tag,
    output logic [15:0]                f_x,
    output logic [15:0]                f_y,
    output logic [15:0]                f_z,
    output logic                       f_mul,
    output logic                       f_add,
    output logic                       f_negr,
    output logic                       f_negz,
    output logic [1:0]                 f_roundmode,
    input  logic [15:0]                f_result,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [15:0]                res_data,
    output logic [3:0]                 res_tag,
    output logic                       err_illegal,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // One queued command with its decoded fma16 controls.
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [1:0]  rm;
        logic [3:0]  tag;
        logic        mul;
        logic        add;
        logic        negr;
        logic        negz;
    } entry_t;

    // Opcode to {mul, add, negr, negz}; the illegal opcode decodes to all zero.
    function automatic logic [3:0] decode_op(input logic [2:0] op);
        logic [3:0] ctl;
        case (op)
            3'b000:  ctl = 4'b0100;  // fadd
            3'b001:  ctl = 4'b0101;  // fsub
            3'b010:  ctl = 4'b1000;  // fmul
            3'b011:  ctl = 4'b1100;  // fmadd
            3'b100:  ctl = 4'b1101;  // fmsub
            3'b101:  ctl = 4'b1110;  // fnmadd
            3'b110:  ctl = 4'b1111;  // fnmsub
            default: ctl = 4'b0000;
        endcase
        return ctl;
    endfunction

    entry_t          mem_r [DEPTH];
    entry_t          head_s;
    entry_t          new_entry_s;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_nxt_s;
    logic            res_valid_r;
    logic [15:0]     res_data_r;
    logic [3:0]      res_tag_r;
    logic            err_illegal_r;
    logic            accept_s;
    logic            push_s;
    logic            pop_s;
    logic            illegal_s;
    logic [3:0]      ctl_s;

    // Handshake qualification: full FIFO refuses even when it pops this cycle.
    always_comb begin
        cmd_ready = (count_r != CW'(DEPTH));
        accept_s  = cmd_valid & cmd_ready;
        push_s    = accept_s & (cmd_op != 3'b111);
        illegal_s = accept_s & (cmd_op == 3'b111);
        pop_s     = (count_r != {CW{1'b0}}) & (~res_valid_r | res_ready);
    end

    // Build the entry to be written, with decode done at enqueue.
    always_comb begin
        ctl_s            = decode_op(cmd_op);
        new_entry_s      = '0;
        new_entry_s.x    = cmd_x;
        new_entry_s.y    = cmd_y;
        new_entry_s.z    = cmd_z;
        new_entry_s.rm   = cmd_rm;
        new_entry_s.tag  = cmd_tag;
        new_entry_s.mul  = ctl_s[3];
        new_entry_s.add  = ctl_s[2];
        new_entry_s.negr = ctl_s[1];
        new_entry_s.negz = ctl_s[0];
    end

    // FIFO storage; contents are only observable through a valid head.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= new_entry_s;
        end
    end

    // Head selection: drive zeros to fma16 whenever the FIFO is empty.
    always_comb begin
        head_s = '0;
        if (count_r != {CW{1'b0}}) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = '0;
        end
    end

    // Occupancy next-state: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Output register: capture the head result when free or being consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid_r <= 1'b0;
            res_data_r  <= 16'h0000;
            res_tag_r   <= 4'h0;
        end else if (pop_s) begin
            res_valid_r <= 1'b1;
            res_data_r  <= f_result;
            res_tag_r   <= head_s.tag;
        end else if (res_ready & res_valid_r) begin
            res_valid_r <= 1'b0;
        end
    end

    // Sticky illegal-opcode flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_illegal_r <= 1'b0;
        end else if (illegal_s) begin
            err_illegal_r <= 1'b1;
        end
    end

    // Port mapping of the head entry and the registered state.
    always_comb begin
        f_x         = head_s.x;
        f_y         = head_s.y;
        f_z         = head_s.z;
        f_roundmode = head_s.rm;
        f_mul       = head_s.mul;
        f_add       = head_s.add;
        f_negr      = head_s.negr;
        f_negz      = head_s.negz;
        res_valid   = res_valid_r;
        res_data    = res_data_r;
        res_tag     = res_tag_r;
        err_illegal = err_illegal_r;
        count       = count_r;
    end

endmodule
